// File: rtl/keccak_pkg.sv
// Shared constants, rate presets and FSM encoding for the Keccak squeeze path.
// Imported by the squeeze controller, its stream interface and store64.
package keccak_pkg;

   localparam int BW_DATA = 64;
   localparam int N_LANE  = 25;
   localparam int BW_IDX  = 5;
   localparam int BW_LEN  = 16;

   localparam int RATE_SHAKE128 = 21;
   localparam int RATE_SHAKE256 = 17;
   localparam int RATE_SHA3_256 = 17;
   localparam int RATE_SHA3_512 = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT  = 2'd1,
      ST_PERM  = 2'd2,
      ST_DRAIN = 2'd3
   } sq_state_e;

   // Legal rates are 1..N_LANE lanes.
   function automatic logic rate_legal(input logic [BW_IDX-1:0] r);
      return (r != '0) && (r <= BW_IDX'(N_LANE));
   endfunction

endpackage

// File: rtl/keccak_squeeze_ctrl_if.sv
// Valid/ready word stream carrying squeezed 64-bit output words.
// master: data, valid out / ready in; slave: the reverse.
interface keccak_squeeze_ctrl_if;
   import keccak_pkg::*;

   logic [BW_DATA-1:0] data;
   logic               valid;
   logic               ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/keccak_squeeze_ctrl_store64.sv
// store64: little-endian byte swap of one 64-bit lane.
// i_data: lane as held in the state; o_data: lane with byte order reversed.
module store64
   import keccak_pkg::*;
(
   input  logic [BW_DATA-1:0] i_data,
   output logic [BW_DATA-1:0] o_data
);

   always_comb begin
      o_data = '0;
      for (int i = 0; i < BW_DATA / 8; i++) begin
         o_data[8*i +: 8] = i_data[BW_DATA-8-8*i +: 8];
      end
   end

endmodule

// File: rtl/keccak_squeeze_ctrl.sv
// Squeeze-phase sequencer: reads rate lanes, byte-swaps them, streams words,
// requests permutations between rate blocks and pulses o_done at the end.
// Ports: i_clk/i_rst, start/rate/nwords command, o_busy, state read port
// (o_lane_idx/i_lane_data), permutation handshake, o_done, out_if stream.
module keccak_squeeze_ctrl
   import keccak_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [BW_IDX-1:0]  i_rate_lanes,
   input  logic [BW_LEN-1:0]  i_nwords,
   output logic               o_busy,
   output logic [BW_IDX-1:0]  o_lane_idx,
   input  logic [BW_DATA-1:0] i_lane_data,
   output logic               o_perm_start,
   input  logic               i_perm_done,
   output logic               o_done,
   keccak_squeeze_ctrl_if.master out_if
);

   sq_state_e          state_q, state_d;
   logic [BW_IDX-1:0]  rate_q, rate_d;
   logic [BW_LEN-1:0]  remain_q, remain_d;
   logic [BW_IDX-1:0]  lane_idx_q, lane_idx_d;
   logic               busy_q, busy_d;
   logic               perm_start_q, perm_start_d;
   logic [BW_DATA-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;

   logic [BW_DATA-1:0] lane_swapped;
   logic               slot_free;
   logic               accept;

   store64 u_store64 (
      .i_data (i_lane_data),
      .o_data (lane_swapped)
   );

   assign slot_free = !valid_q || out_if.ready;
   assign accept    = i_start && !busy_q && rate_legal(i_rate_lanes);

   always_comb begin
      state_d      = state_q;
      rate_d       = rate_q;
      remain_d     = remain_q;
      lane_idx_d   = lane_idx_q;
      busy_d       = busy_q;
      perm_start_d = 1'b0;
      data_d       = data_q;
      valid_d      = valid_q;
      done_d       = 1'b0;

      // Pending word leaves on handshake in any state; a load below
      // overrides this in the same cycle.
      if (valid_q && out_if.ready) begin
         valid_d = 1'b0;
      end

      // busy stays up through the o_done cycle, drops right after.
      if (done_q) begin
         busy_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (state_q == ST_IDLE && accept) begin
               rate_d     = i_rate_lanes;
               remain_d   = i_nwords;
               lane_idx_d = '0;
               busy_d     = 1'b1;
               state_d    = (i_nwords == '0) ? ST_DRAIN : ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (slot_free) begin
               data_d     = lane_swapped;
               valid_d    = 1'b1;
               remain_d   = remain_q - BW_LEN'(1);
               lane_idx_d = lane_idx_q + BW_IDX'(1);
               if (remain_q == BW_LEN'(1)) begin
                  state_d = ST_DRAIN;
               end else if (lane_idx_q == rate_q - BW_IDX'(1)) begin
                  state_d      = ST_PERM;
                  lane_idx_d   = '0;
                  perm_start_d = 1'b1;
               end
            end
         end
         ST_PERM: begin
            // Completion is only looked at after the request cycle.
            if (!perm_start_q && i_perm_done) begin
               state_d = ST_EMIT;
            end
         end
         ST_DRAIN: begin
            if (slot_free) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         rate_q       <= '0;
         remain_q     <= '0;
         lane_idx_q   <= '0;
         busy_q       <= 1'b0;
         perm_start_q <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rate_q       <= rate_d;
         remain_q     <= remain_d;
         lane_idx_q   <= lane_idx_d;
         busy_q       <= busy_d;
         perm_start_q <= perm_start_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
      end
   end

   assign o_busy       = busy_q;
   assign o_lane_idx   = lane_idx_q;
   assign o_perm_start = perm_start_q;
   assign o_done       = done_q;
   assign out_if.data  = data_q;
   assign out_if.valid = valid_q;

   a_hold: assert property (@(posedge i_clk) disable iff (i_rst)
      valid_q && !out_if.ready |=> valid_q && $stable(data_q));

   a_perm_pulse: assert property (@(posedge i_clk) disable iff (i_rst)
      perm_start_q |=> !perm_start_q);

endmodule

// File: doc/keccak_squeeze_ctrl.md
# keccak_squeeze_ctrl

Sequences the squeeze phase of the Keccak sponge. It reads 64-bit lanes of the rate portion from the permutation state array in order and passes each through the little-endian byte-swap unit `store64`. Each swapped lane is emitted as one 64-bit word on a valid/ready stream. When the rate is exhausted, it requests another permutation. It sits between the Keccak state/permutation core and the Kyber consumers of SHAKE/SHA3 output: the matrix sampler and the CBD sampler.

## Interface
- BW_DATA, 64, lane / output word width
- N_LANE, 25, lanes in Keccak state
- BW_IDX, 5, lane index width
- BW_LEN, 16, width of requested output length (in words)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset: one clock; reset is synchronous and active-high
- i_start  in  1  one-cycle request to begin squeezing
- i_rate_lanes  in  BW_IDX  rate in lanes, legal 1..25 (21 = SHAKE128, 17 = SHAKE256/SHA3-256, 9 = SHA3-512)
- i_nwords  in  BW_LEN  number of 64-bit words to emit
- o_busy  out  1  high from the cycle after an accepted start through the o_done cycle
- o_lane_idx  out  BW_IDX  state read address; i_lane_data is combinational for the same cycle
- i_lane_data  in  BW_DATA  state lane at o_lane_idx
- o_perm_start  out  1  one-cycle permutation request
- i_perm_done  in  1  one-cycle permutation completion
- o_data  out  BW_DATA  byte-swapped lane
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts when o_valid & i_ready
- o_done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, EMIT, PERM, DRAIN.
- IDLE:
  - i_start is accepted only when the rate is in 1..25.
  - It is otherwise ignored, as is any start while busy.
  - On accept: latch the rate, remaining = i_nwords, lane_idx = 0.
  - If i_nwords == 0, go to DRAIN; otherwise go to EMIT.
- EMIT: the output slot is free when !o_valid || i_ready. When the slot is free:
  - load o_data = store64(i_lane_data) and set o_valid = 1;
  - decrement remaining and increment lane_idx.
- Leaving EMIT on a load:
  - After the load with remaining reaching 0: go to DRAIN.
  - After the load of lane rate-1 with remaining > 0: go to PERM and reset lane_idx to 0.
- PERM:
  - o_perm_start is high on the first PERM cycle only.
  - i_perm_done is sampled only from the cycle after o_perm_start. When sampled high, go to EMIT.
  - The pending output word stays held and may be accepted during PERM.
- DRAIN: wait until the output slot is empty or accepted this cycle. Then pulse o_done, clear o_busy and go to IDLE.
- i_perm_done outside PERM is ignored. o_perm_start is never reasserted before i_perm_done.
- The state is assumed already permuted when start is issued: the absorb controller runs the first permutation.
- Reset mid-operation: return to IDLE immediately and drop any pending word without completion.
- Reset values: o_busy 0, o_lane_idx 0, o_perm_start 0, o_data 0, o_valid 0, o_done 0.

## Timing
- Start sampled at cycle 0:
  - EMIT in cycle 1 with o_lane_idx = 0;
  - first word valid in cycle 2.
- With i_ready held high: word k appears in cycle 2+k, for k < rate.
- Permutation bubble:
  - lane rate-1 loaded in cycle rate;
  - o_perm_start in cycle rate+1;
  - i_perm_done in cycle t gives EMIT in t+1 and the next word valid in t+2.
- Backpressure: o_data and o_valid stay stable while o_valid & !i_ready. No word is lost or duplicated.
- Last word accepted in cycle a: o_done in cycle a+1 and o_busy low in a+2.
- i_nwords == 0: o_done in cycle 2 with no output.

## Structure
- keccak_pkg holds:
  - N_LANE;
  - rate constants RATE_SHAKE128 = 21, RATE_SHAKE256 = 17, RATE_SHA3_256 = 17, RATE_SHA3_512 = 9;
  - the FSM state encoding.
- One sub-module: the existing `store64` byte-swap, instantiated on the i_lane_data → o_data path.

## Test plan
- Rate 21, 5 words, ready high: lanes 0..4 emitted in cycles 2..6, each byte-reversed. Lane 0 = 64'h0123456789ABCDEF gives o_data 64'hEFCDAB8967452301. o_done in cycle 7. No o_perm_start.
- Rate 17, 20 words: 17 words, then one o_perm_start. Done returned 4 cycles later. Words 18..20 come from lanes 0..2 of the new state. Exactly 20 accepted handshakes.
- Random i_ready (50%) with rate 21 and 50 words: order matches lane sequence, data is held stable while stalled, exactly 2 permutations.
- i_nwords = 0 gives o_done in cycle 2 with no valid. i_rate_lanes = 0 or 26 gives start ignored and o_busy staying 0.
- Spurious i_perm_done in EMIT is ignored. Reset in PERM with o_valid high gives o_valid 0 and IDLE next cycle; a fresh start then works normally.
